// File: rtl/key_debounce_array_if.sv
// Key-side signal bundle: raw key levels in, debounced levels and event pulses out.
interface key_debounce_array_if #(
  parameter int unsigned NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] key_in;
  logic [NUM_KEYS-1:0] key_state;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_KEYS-1:0] key_long;
  logic [NUM_KEYS-1:0] key_repeat;

  modport master (
    output key_in,
    input  key_state, key_press, key_release, key_long, key_repeat
  );

  modport slave (
    input  key_in,
    output key_state, key_press, key_release, key_long, key_repeat
  );
endinterface

// File: rtl/key_debounce_array.sv
// Multi-channel key debouncer: per-key 2-flop synchroniser, 4-state filter FSM,
// debounce and hold counters, with press/release/long-press/auto-repeat pulses.
module key_debounce_array #(
  parameter int unsigned NUM_KEYS      = 4,
  parameter int unsigned DEB_CYCLES    = 1_000_000,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter int unsigned LONG_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
  input logic                  CLK,
  input logic                  nRST,
  key_debounce_array_if.slave  keys
);

  localparam int unsigned DW        = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned HMAX      = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HW        = (HMAX > 1) ? $clog2(HMAX) : 1;
  localparam int unsigned DEB_LAST  = DEB_CYCLES - 1;
  localparam int unsigned LONG_LAST = (LONG_CYCLES > 0) ? LONG_CYCLES - 1 : 0;
  localparam int unsigned REP_LAST  = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;
  localparam logic        IDLE_LVL  = ACTIVE_LOW;

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    FILT_DN = 4'b0010,
    DOWN    = 4'b0100,
    FILT_UP = 4'b1000
  } state_e;

  logic [NUM_KEYS-1:0] sync1_q, sync2_q, p;

  state_e          state_q     [NUM_KEYS];
  state_e          state_d     [NUM_KEYS];
  logic [DW-1:0]   dcnt_q      [NUM_KEYS];
  logic [DW-1:0]   dcnt_d      [NUM_KEYS];
  logic [HW-1:0]   hcnt_q      [NUM_KEYS];
  logic [HW-1:0]   hcnt_d      [NUM_KEYS];
  logic [NUM_KEYS-1:0] long_done_q, long_done_d;

  logic [NUM_KEYS-1:0] level_q, level_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;
  logic [NUM_KEYS-1:0] long_q, long_d;
  logic [NUM_KEYS-1:0] repeat_q, repeat_d;

  // Synchroniser resets to the idle level so reset release cannot look like a press.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      sync1_q <= {NUM_KEYS{IDLE_LVL}};
      sync2_q <= {NUM_KEYS{IDLE_LVL}};
    end else begin
      sync1_q <= keys.key_in;
      sync2_q <= sync1_q;
    end
  end

  assign p = sync2_q ^ {NUM_KEYS{IDLE_LVL}};

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        state_q[i] <= IDLE;
        dcnt_q[i]  <= '0;
        hcnt_q[i]  <= '0;
      end
      long_done_q <= '0;
      level_q     <= '0;
      press_q     <= '0;
      release_q   <= '0;
      long_q      <= '0;
      repeat_q    <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        state_q[i] <= state_d[i];
        dcnt_q[i]  <= dcnt_d[i];
        hcnt_q[i]  <= hcnt_d[i];
      end
      long_done_q <= long_done_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      repeat_q    <= repeat_d;
    end
  end

  // Per-channel filter FSM; every counter compare also clears the counter, so none wrap.
  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    hcnt_d      = hcnt_q;
    long_done_d = long_done_q;
    level_d     = '0;
    press_d     = '0;
    release_d   = '0;
    long_d      = '0;
    repeat_d    = '0;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      case (state_q[i])
        IDLE: begin
          if (p[i]) begin
            state_d[i] = FILT_DN;
            dcnt_d[i]  = '0;
          end
        end
        FILT_DN: begin
          if (!p[i]) begin
            state_d[i] = IDLE;
            dcnt_d[i]  = '0;
          end else if (dcnt_q[i] == DW'(DEB_LAST)) begin
            state_d[i]     = DOWN;
            dcnt_d[i]      = '0;
            hcnt_d[i]      = '0;
            long_done_d[i] = 1'b0;
            press_d[i]     = 1'b1;
          end else begin
            dcnt_d[i] = dcnt_q[i] + DW'(1);
          end
        end
        DOWN: begin
          if (!p[i]) begin
            state_d[i] = FILT_UP;
            dcnt_d[i]  = '0;
          end else if ((LONG_CYCLES > 0) && !long_done_q[i]) begin
            if (hcnt_q[i] == HW'(LONG_LAST)) begin
              long_d[i]      = 1'b1;
              long_done_d[i] = 1'b1;
              hcnt_d[i]      = '0;
            end else begin
              hcnt_d[i] = hcnt_q[i] + HW'(1);
            end
          end else if (long_done_q[i] && (REPEAT_CYCLES > 0)) begin
            if (hcnt_q[i] == HW'(REP_LAST)) begin
              repeat_d[i] = 1'b1;
              hcnt_d[i]   = '0;
            end else begin
              hcnt_d[i] = hcnt_q[i] + HW'(1);
            end
          end
        end
        FILT_UP: begin
          // Hold timing is frozen here and resumes if the key bounces back down.
          if (p[i]) begin
            state_d[i] = DOWN;
            dcnt_d[i]  = '0;
          end else if (dcnt_q[i] == DW'(DEB_LAST)) begin
            state_d[i]   = IDLE;
            dcnt_d[i]    = '0;
            release_d[i] = 1'b1;
          end else begin
            dcnt_d[i] = dcnt_q[i] + DW'(1);
          end
        end
        default: begin
          state_d[i]     = IDLE;
          dcnt_d[i]      = '0;
          hcnt_d[i]      = '0;
          long_done_d[i] = 1'b0;
        end
      endcase
      level_d[i] = (state_d[i] == DOWN) || (state_d[i] == FILT_UP);
    end
  end

  assign keys.key_state   = level_q;
  assign keys.key_press   = press_q;
  assign keys.key_release = release_q;
  assign keys.key_long    = long_q;
  assign keys.key_repeat  = repeat_q;

endmodule

// File: doc/key_debounce_array.md
# key_debounce_array

Parametrised multi-channel key debouncer, the successor to the single-key filter FSM. It debounces NUM_KEYS independent key inputs, each with its own synchroniser, 4-state filter FSM and counters. Each channel reports debounced press/release pulses, a level state, and optional long-press and auto-repeat pulses. It sits between the matrix-keyboard scan/IO pins and the key decoder.

## Interface
- NUM_KEYS, 4: number of independent channels (≥1).
- DEB_CYCLES, 1_000_000: cycles the synchronised level must stay stable to accept a transition (≥1; 20 ms at 50 MHz).
- ACTIVE_LOW, 1: 1 means a pressed key reads 0 on KEY_IN.
- LONG_CYCLES, 50_000_000: debounced-held cycles before KEY_LONG fires; 0 disables both long-press and repeat.
- REPEAT_CYCLES, 10_000_000: KEY_REPEAT period after KEY_LONG; 0 disables repeat.
- CLK  input  1  system clock, all logic on rising edge.
- nRST  input  1  reset; asynchronous and active-low.
- KEY_IN  input  NUM_KEYS  raw asynchronous key levels.
- KEY_STATE  output  NUM_KEYS  debounced level, 1 = pressed.
- KEY_PRESS  output  NUM_KEYS  1-cycle pulse on accepted press.
- KEY_RELEASE  output  NUM_KEYS  1-cycle pulse on accepted release.
- KEY_LONG  output  NUM_KEYS  1-cycle pulse once per hold, after LONG_CYCLES.
- KEY_REPEAT  output  NUM_KEYS  1-cycle pulse every REPEAT_CYCLES after KEY_LONG.

## Operation
- **Synchroniser:** per channel, 2 flops. Reset value is the idle level (1 if ACTIVE_LOW, else 0), so reset release never creates a false edge. `p` is the synchronised level, normalised to 1 = pressed.
- **FSM states:** one-hot IDLE, FILT_DN, DOWN, FILT_UP. An illegal encoding goes to IDLE with all of that channel's outputs 0.
- **IDLE:**
  - p=1: go to FILT_DN, dcnt=0.
  - p=0: stay.
- **FILT_DN:**
  - p=0: go to IDLE, dcnt=0, no pulse.
  - p=1 and dcnt==DEB_CYCLES-1: go to DOWN, KEY_PRESS=1, KEY_STATE=1, hcnt=0, long_done=0.
  - Otherwise: dcnt+1.
- **DOWN:**
  - p=0: go to FILT_UP, dcnt=0.
  - p=1 with LONG_CYCLES>0 and long_done=0: hcnt+1. When hcnt==LONG_CYCLES-1: KEY_LONG=1, long_done=1, hcnt=0.
  - p=1 with long_done=1 and REPEAT_CYCLES>0: hcnt+1. When hcnt==REPEAT_CYCLES-1: KEY_REPEAT=1, hcnt=0.
- **FILT_UP:**
  - p=1: go back to DOWN, dcnt=0. hcnt and long_done keep their values; hold timing resumes.
  - p=0 and dcnt==DEB_CYCLES-1: go to IDLE, KEY_RELEASE=1, KEY_STATE=0.
  - Otherwise: dcnt+1.
  - hcnt is frozen and no LONG/REPEAT pulses are issued here.
- **Counter widths:**
  - dcnt: $clog2(DEB_CYCLES), minimum 1 bit.
  - hcnt: $clog2(max(LONG_CYCLES,REPEAT_CYCLES)), minimum 1 bit.
  - Counters never wrap, because every compare resets them.
- Channels are fully independent. Simultaneous events on different channels are all reported in the same cycle.

## Timing
- All outputs are registered. Every output resets to 0, every FSM to IDLE, and every counter to 0.
- **Press latency:** KEY_IN first sampled pressed at edge 0 and held → FSM enters FILT_DN at edge 2. KEY_PRESS and KEY_STATE rise at edge DEB_CYCLES+2; KEY_PRESS falls at the next edge.
- **Release latency:** symmetric; KEY_RELEASE rises and KEY_STATE falls at edge DEB_CYCLES+2 after the first released sample.
- **KEY_LONG** rises LONG_CYCLES edges after KEY_PRESS, provided there is no excursion into FILT_UP.
- **KEY_REPEAT** rises every REPEAT_CYCLES edges after that.
- **Bounces:** a bounce shorter than DEB_CYCLES cycles (as seen at the synchroniser output) produces no pulse and no KEY_STATE change.
- **Pulse counts:** exactly one KEY_PRESS and one KEY_RELEASE per accepted cycle. KEY_STATE is 1 throughout DOWN and FILT_UP.
- **Reset mid-operation:** all channels abort immediately with no release pulse.
- **Key held through reset:** reported as a new press at edge DEB_CYCLES+2 after reset release.

## Test plan
All scenarios use NUM_KEYS=4, DEB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, ACTIVE_LOW=1.

- **Clean press:** key0 driven 1→0 and held → KEY_PRESS[0] pulses once at edge 6 after first low sample, KEY_STATE[0]=1. Other channels stay 0.
- **Bounce rejection:** key1 low for 3 cycles, then high, repeated 5 times, then stable low → no pulse during the bounces; a single KEY_PRESS[1] 6 edges after the final stable low.
- **Long/repeat:** key2 held for 60 cycles after KEY_PRESS → KEY_LONG[2] at +20 edges, then KEY_REPEAT[2] at +28, +36, +44, +52, +60. On release, KEY_RELEASE[2] fires after 6 edges.
- **Release glitch:** key2 held, then a 2-cycle high glitch → stays in DOWN with no KEY_RELEASE; hold timing resumes with the frozen hcnt.
- **Simultaneous press:** keys 0 and 3 pressed on the same edge → KEY_PRESS 4'b1001 in the same cycle.
- **Reset mid-operation:** nRST asserted mid-hold, key0 kept low → all outputs 0 immediately. After release, KEY_PRESS[0] fires at edge 6.
